// File: rtl/frame_ctrl_if.sv
// Request, configuration and pixel-stream bundle shared by frame_ctrl and its upstream driver.
// Handshakes: a transfer happens on a clock edge where valid & ready are both high; valid, once raised, holds with its payload until that edge.
interface frame_ctrl_if #(
   parameter int IMG_WIDTH  = 8,
   parameter int MEM_AWIDTH = 16
);
   logic [MEM_AWIDTH-1:0] req_width;
   logic [MEM_AWIDTH-1:0] req_height;
   logic                  req_val;
   logic                  req_rdy;
   logic                  cfg_err;
   logic [MEM_AWIDTH-1:0] cfg_delay;
   logic                  cfg_set;
   logic [IMG_WIDTH-1:0]  up_data;
   logic                  up_val;
   logic                  up_rdy;
   logic [IMG_WIDTH-1:0]  dn_data;
   logic                  dn_val;
   logic                  frame_done;

   modport master (
      output req_width, req_height, req_val, up_data, up_val,
      input  req_rdy, cfg_err, cfg_delay, cfg_set, up_rdy, dn_data, dn_val, frame_done
   );

   modport slave (
      input  req_width, req_height, req_val, up_data, up_val,
      output req_rdy, cfg_err, cfg_delay, cfg_set, up_rdy, dn_data, dn_val, frame_done
   );
endinterface

// File: rtl/frame_ctrl.sv
// Frame-boundary configuration sequencer with registered pixel pass-through.
// Optional line-buffer flush after each frame is enabled by defining FRAME_CTRL_FLUSH_EN.
module frame_ctrl #(
   parameter int WIDTH_NB   = 3,
   parameter int IMG_WIDTH  = 8,
   parameter int MEM_AWIDTH = 16,
   parameter int SETTLE_CYC = 2
) (
   input  logic        clk,
   input  logic        rst,
   frame_ctrl_if.slave bus,
   output logic [2:0]  dbg_state_o
);
   localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [MEM_AWIDTH-1:0] MIN_W       = MEM_AWIDTH'(WIDTH_NB);
   localparam logic [MEM_AWIDTH-1:0] ONE         = MEM_AWIDTH'(1);
   localparam logic [SW-1:0]         SETTLE_LAST = SW'(SETTLE_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_SETTLE = 3'd2,
      S_RUN    = 3'd3,
      S_FLUSH  = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic                  pend_val_q, pend_val_d;
   logic [MEM_AWIDTH-1:0] pend_w_q, pend_w_d;
   logic [MEM_AWIDTH-1:0] pend_h_q, pend_h_d;
   logic [MEM_AWIDTH-1:0] cfg_delay_q, cfg_delay_d;
   logic [MEM_AWIDTH-1:0] act_h_q, act_h_d;
   logic [MEM_AWIDTH-1:0] col_q, col_d;
   logic [MEM_AWIDTH-1:0] row_q, row_d;
   logic [SW-1:0]         settle_q, settle_d;
   logic                  cfg_set_q, cfg_set_d;
   logic                  cfg_err_q, cfg_err_d;
   logic                  dn_val_q, dn_val_d;
   logic [IMG_WIDTH-1:0]  dn_data_q, dn_data_d;
   logic                  frame_done_q, frame_done_d;

   logic req_rdy, req_acc, req_legal, up_rdy, up_acc, col_last, row_last;

`ifdef FRAME_CTRL_FLUSH_EN
   localparam int FW = MEM_AWIDTH + 2;
   logic [FW-1:0] flush_q, flush_d;
   logic          flush_last;
   // One beat per buffered line pixel: cfg_delay * (WIDTH_NB-1) beats in total.
   assign flush_last = (flush_q == (FW'(cfg_delay_q) * FW'(WIDTH_NB - 1)) - FW'(1));
`endif

   assign req_rdy   = ~rst & ~pend_val_q;
   assign req_acc   = bus.req_val & req_rdy;
   assign req_legal = (bus.req_width >= MIN_W) && (bus.req_height != '0);
   assign up_rdy    = (state_q == S_RUN);
   assign up_acc    = bus.up_val & up_rdy;
   assign col_last  = (col_q == cfg_delay_q - ONE);
   assign row_last  = (row_q == act_h_q - ONE);

   always_comb begin
      state_d      = state_q;
      pend_val_d   = pend_val_q;
      pend_w_d     = pend_w_q;
      pend_h_d     = pend_h_q;
      cfg_delay_d  = cfg_delay_q;
      act_h_d      = act_h_q;
      col_d        = col_q;
      row_d        = row_q;
      settle_d     = settle_q;
      cfg_set_d    = 1'b0;
      cfg_err_d    = 1'b0;
      dn_val_d     = 1'b0;
      dn_data_d    = '0;
      frame_done_d = 1'b0;
`ifdef FRAME_CTRL_FLUSH_EN
      flush_d      = flush_q;
`endif

      // The slot only accepts while empty, so filling never collides with LOAD clearing it.
      if (req_acc) begin
         if (req_legal) begin
            pend_val_d = 1'b1;
            pend_w_d   = bus.req_width;
            pend_h_d   = bus.req_height;
         end else begin
            cfg_err_d  = 1'b1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (pend_val_q) state_d = S_LOAD;
         end
         S_LOAD: begin
            cfg_delay_d = pend_w_q;
            act_h_d     = pend_h_q;
            pend_val_d  = 1'b0;
            cfg_set_d   = 1'b1;
            col_d       = '0;
            row_d       = '0;
            settle_d    = '0;
            state_d     = S_SETTLE;
         end
         S_SETTLE: begin
            if (settle_q == SETTLE_LAST) state_d = S_RUN;
            else settle_d = settle_q + SW'(1);
         end
         S_RUN: begin
            if (up_acc) begin
               dn_val_d  = 1'b1;
               dn_data_d = bus.up_data;
               if (col_last) begin
                  col_d = '0;
                  if (row_last) begin
                     row_d        = '0;
                     frame_done_d = 1'b1;
`ifdef FRAME_CTRL_FLUSH_EN
                     flush_d      = '0;
                     state_d      = S_FLUSH;
`else
                     if (pend_val_d) state_d = S_LOAD;
`endif
                  end else begin
                     row_d = row_q + ONE;
                  end
               end else begin
                  col_d = col_q + ONE;
               end
            end
         end
`ifdef FRAME_CTRL_FLUSH_EN
         S_FLUSH: begin
            dn_val_d = 1'b1;
            if (flush_last) state_d = pend_val_d ? S_LOAD : S_RUN;
            else flush_d = flush_q + FW'(1);
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         pend_val_q   <= 1'b0;
         pend_w_q     <= '0;
         pend_h_q     <= '0;
         cfg_delay_q  <= '0;
         act_h_q      <= '0;
         col_q        <= '0;
         row_q        <= '0;
         settle_q     <= '0;
         cfg_set_q    <= 1'b0;
         cfg_err_q    <= 1'b0;
         dn_val_q     <= 1'b0;
         dn_data_q    <= '0;
         frame_done_q <= 1'b0;
`ifdef FRAME_CTRL_FLUSH_EN
         flush_q      <= '0;
`endif
      end else begin
         state_q      <= state_d;
         pend_val_q   <= pend_val_d;
         pend_w_q     <= pend_w_d;
         pend_h_q     <= pend_h_d;
         cfg_delay_q  <= cfg_delay_d;
         act_h_q      <= act_h_d;
         col_q        <= col_d;
         row_q        <= row_d;
         settle_q     <= settle_d;
         cfg_set_q    <= cfg_set_d;
         cfg_err_q    <= cfg_err_d;
         dn_val_q     <= dn_val_d;
         dn_data_q    <= dn_data_d;
         frame_done_q <= frame_done_d;
`ifdef FRAME_CTRL_FLUSH_EN
         flush_q      <= flush_d;
`endif
      end
   end

   assign bus.req_rdy    = req_rdy;
   assign bus.up_rdy     = up_rdy;
   assign bus.cfg_err    = cfg_err_q;
   assign bus.cfg_delay  = cfg_delay_q;
   assign bus.cfg_set    = cfg_set_q;
   assign bus.dn_data    = dn_data_q;
   assign bus.dn_val     = dn_val_q;
   assign bus.frame_done = frame_done_q;
   assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_frame_ctrl.sv
// Randomized self-checking bench for frame_ctrl against a frame/slot-level reference model.
module tb_frame_ctrl;
   localparam int WNB = 3;
   localparam int IW  = 8;
   localparam int AW  = 16;
   localparam int SC  = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] dbg_state;
   int         n_checks = 0;
   int         n_fail   = 0;

   frame_ctrl_if #(.IMG_WIDTH(IW), .MEM_AWIDTH(AW)) bus ();

   frame_ctrl #(.WIDTH_NB(WNB), .IMG_WIDTH(IW), .MEM_AWIDTH(AW), .SETTLE_CYC(SC)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: a queue of accepted geometries, the frame in flight as a pixel
   // index, and cycle timers until the next cfg_set pulse and until pixels flow again.
   typedef struct packed {
      logic [AW-1:0] w;
      logic [AW-1:0] h;
   } geom_t;

   geom_t          pend_q[$];
   geom_t          g;
   int             cur_w, cur_h, pix, cfg_in, run_in, flush_left, cfg_dly;
   bit             run;
   logic           exp_val, exp_fd, exp_err;
   logic [IW-1:0]  exp_data;
   logic           req_hs;
   bit             up_acc, req_acc;

   task automatic model_reset();
      pend_q.delete();
      cur_w = 0; cur_h = 0; pix = 0; cfg_in = -1; run_in = -1; flush_left = 0; cfg_dly = 0;
      run = 0; exp_val = 0; exp_fd = 0; exp_err = 0; exp_data = '0; req_hs = 0;
   endtask

   initial begin
      model_reset();
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("rst_dn_val", bus.dn_val, 0);
            chk("rst_dn_data", bus.dn_data, 0);
            chk("rst_cfg_set", bus.cfg_set, 0);
            chk("rst_cfg_delay", bus.cfg_delay, 0);
            chk("rst_frame_done", bus.frame_done, 0);
            chk("rst_cfg_err", bus.cfg_err, 0);
            chk("rst_up_rdy", bus.up_rdy, 0);
            chk("rst_req_rdy", bus.req_rdy, 0);
            model_reset();
         end else begin
            if (cfg_in == 0) begin
               g = pend_q.pop_front();
               cur_w = int'(g.w); cur_h = int'(g.h); cfg_dly = int'(g.w); pix = 0;
            end
            if (run_in == 0) run = 1;
            chk("cfg_set", bus.cfg_set, (cfg_in == 0));
            chk("cfg_delay", bus.cfg_delay, cfg_dly);
            chk("req_rdy", bus.req_rdy, (pend_q.size() == 0));
            chk("up_rdy", bus.up_rdy, run);
            chk("dn_val", bus.dn_val, exp_val);
            if (exp_val) chk("dn_data", bus.dn_data, exp_data);
            chk("frame_done", bus.frame_done, exp_fd);
            chk("cfg_err", bus.cfg_err, exp_err);

            req_hs  = bus.req_val && bus.req_rdy;
            req_acc = bus.req_val && (pend_q.size() == 0);
            up_acc  = bus.up_val && run;
            exp_err = 0; exp_val = 0; exp_fd = 0; exp_data = '0;
            if (req_acc) begin
               if (int'(bus.req_width) >= WNB && bus.req_height != 0)
                  pend_q.push_back({bus.req_width, bus.req_height});
               else
                  exp_err = 1;
            end
            if (cfg_in >= 0) cfg_in--;
            if (run_in >= 0) run_in--;
            if (up_acc) begin
               exp_val = 1; exp_data = bus.up_data; pix++;
               if (pix == cur_w * cur_h) begin
                  pix = 0; exp_fd = 1;
`ifdef FRAME_CTRL_FLUSH_EN
                  run = 0; flush_left = cfg_dly * (WNB - 1);
`else
                  if (pend_q.size() > 0) begin
                     run = 0; cfg_in = 1; run_in = 1 + SC;
                  end
`endif
               end
            end else if (flush_left > 0) begin
               exp_val = 1; flush_left--;
               if (flush_left == 0) begin
                  if (pend_q.size() > 0) begin
                     cfg_in = 1; run_in = 1 + SC;
                  end else begin
                     run = 1;
                  end
               end
            end else if (!run && cfg_in < 0 && run_in < 0 && pend_q.size() > 0) begin
               cfg_in = 2; run_in = 2 + SC;
            end
         end
      end
   end

   initial begin
      bus.up_data = '0;
      forever begin
         @(posedge clk);
         #1 bus.up_data = IW'($urandom);
      end
   end

   task automatic drive_req(input int w, input int h);
      bit got = 0;
      bus.req_width  = AW'(w);
      bus.req_height = AW'(h);
      bus.req_val    = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.req_rdy) begin
            got = 1;
            break;
         end
      end
      if (!got) chk("req_hs_timeout", bus.req_rdy, 1);
      @(posedge clk);
      #1 bus.req_val = 1'b0;
   endtask

   task automatic wait_up_rdy();
      bit got = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.up_rdy) begin
            got = 1;
            break;
         end
      end
      if (!got) chk("up_rdy_timeout", bus.up_rdy, 1);
   endtask

   initial begin
      rst = 1'b1;
      bus.req_val = 1'b0; bus.req_width = '0; bus.req_height = '0; bus.up_val = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Continuous 8x2 frames; a 5x1 request lands mid-frame and must wait for the boundary.
      bus.up_val = 1'b1;
      drive_req(8, 2);
      wait_up_rdy();
      repeat (2) @(posedge clk);
      #1;
      drive_req(5, 1);
      repeat (40) @(posedge clk);
      #1;
      drive_req(2, 4);
      repeat (10) @(posedge clk);
      #1;
      drive_req(4, 0);
      repeat (10) @(posedge clk);
      #1;

      // Reset in the middle of an 8x2 frame.
      drive_req(8, 2);
      wait_up_rdy();
      repeat (4) @(posedge clk);
      #3 rst = 1'b1; bus.req_val = 1'b0; bus.up_val = 1'b0;
      #1;
      chk("async_dn_val", bus.dn_val, 0);
      chk("async_up_rdy", bus.up_rdy, 0);
      chk("async_req_rdy", bus.req_rdy, 0);
      chk("async_cfg_delay", bus.cfg_delay, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      bus.up_val = 1'b1;
      repeat (6) @(posedge clk);
      #1;

      // Short frames with full-rate pixels so requests often coincide with a last pixel.
      drive_req(3, 1);
      for (int c = 0; c < 300; c++) begin
         @(posedge clk);
         #1;
         if (!bus.req_val || req_hs) begin
            if ($urandom_range(0, 3) == 0) begin
               bus.req_val    = 1'b1;
               bus.req_width  = AW'($urandom_range(3, 4));
               bus.req_height = AW'($urandom_range(1, 2));
            end else begin
               bus.req_val = 1'b0;
            end
         end
      end

      // Fully random traffic, including illegal geometries and gaps in the pixel stream.
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #1;
         if (!bus.req_val || req_hs) begin
            if ($urandom_range(0, 7) == 0) begin
               bus.req_val    = 1'b1;
               bus.req_width  = AW'($urandom_range(1, 12));
               bus.req_height = AW'($urandom_range(0, 3));
            end else begin
               bus.req_val = 1'b0;
            end
         end
         bus.up_val = ($urandom_range(0, 3) != 0);
      end

      @(posedge clk);
      #1 bus.req_val = 1'b0; bus.up_val = 1'b1;
      repeat (150) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
